// File: rtl/mrd_pkg.sv
// Shared types for the mixed-radix DFT stage sequencer: radix codes,
// per-stage configuration record and sequencer state encoding.
package mrd_pkg;
  localparam int MAX_STAGES = 6;
  localparam int GRP_W      = 10;
  localparam int TW_W       = 8;

  localparam logic [2:0] RDX2 = 3'd2;
  localparam logic [2:0] RDX3 = 3'd3;
  localparam logic [2:0] RDX4 = 3'd4;
  localparam logic [2:0] RDX5 = 3'd5;

  typedef struct packed {
    logic [2:0]       factor;
    logic [GRP_W-1:0] groups;
    logic [TW_W-1:0]  tw_step;
    logic [TW_W-1:0]  tw_ceil;
    logic [TW_W-1:0]  tw_time;
  } stage_cfg_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_NEXT, S_FIN} state_t;

  function automatic logic factor_ok(input logic [2:0] f);
    return (f == RDX2) || (f == RDX3) || (f == RDX4) || (f == RDX5);
  endfunction
endpackage

// File: rtl/mrd_outst_cnt.sv
// In-flight group counter: +1 per issue, -1 per write-back, saturating at 0
// with an underflow flag for write-backs that have nothing to retire.
module mrd_outst_cnt #(
  parameter int MAX_OUTST = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero,
  output logic underflow
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                     cnt <= '0;
    else if (inc && !dec && !full)  cnt <= cnt + 1'b1;
    else if (dec && !inc && !zero)  cnt <= cnt - 1'b1;
  end

  assign full      = (cnt == CNT_W'(MAX_OUTST));
  assign zero      = (cnt == '0);
  assign underflow = dec && !inc && zero;
endmodule

// File: rtl/mrd_rdx_stage_sched.sv
// Stage sequencer for the mixed-radix DFT engine: walks every stage, issues one
// read per butterfly group and drains write-backs before the radix changes.
module mrd_rdx_stage_sched #(
  parameter int MAX_STAGES = mrd_pkg::MAX_STAGES,
  parameter int wGRP       = mrd_pkg::GRP_W,
  parameter int wTW        = mrd_pkg::TW_W,
  parameter int MAX_OUTST  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [2:0]                      cfg_num_stages,
  input  logic [MAX_STAGES-1:0][2:0]      cfg_factor,
  input  logic [MAX_STAGES-1:0][wGRP-1:0] cfg_groups,
  input  logic [MAX_STAGES-1:0][wTW-1:0]  cfg_tw_step,
  input  logic [MAX_STAGES-1:0][wTW-1:0]  cfg_tw_ceil,
  input  logic [MAX_STAGES-1:0][wTW-1:0]  cfg_tw_time,
  output logic                            rd_req,
  input  logic                            rd_ready,
  output logic [wGRP-1:0]                 rd_grp,
  output logic [2:0]                      stage,
  output logic [2:0]                      factor,
  output logic [wTW-1:0]                  tw_step,
  output logic [wTW-1:0]                  tw_ceil,
  output logic [wTW-1:0]                  tw_time,
  input  logic                            wb_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  import mrd_pkg::*;

  state_t          state_q, state_d;
  stage_cfg_t      cfg_q [MAX_STAGES];
  stage_cfg_t      cur_q;
  logic [2:0]      nstg_q, stage_q;
  logic [wGRP-1:0] grp_q;
  logic            err_q, cfg_ok, xfer, last_grp, last_stg;
  logic            full, zero, uflow;

  mrd_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_outst (
    .clk(clk), .rst_n(rst_n), .inc(xfer), .dec(wb_valid),
    .full(full), .zero(zero), .underflow(uflow)
  );

  // Only the stages actually used must carry a legal radix and group count.
  always_comb begin
    cfg_ok = (cfg_num_stages != 3'd0) && (int'(cfg_num_stages) <= MAX_STAGES);
    for (int i = 0; i < MAX_STAGES; i++)
      if (i < int'(cfg_num_stages) && (!factor_ok(cfg_factor[i]) || cfg_groups[i] == '0))
        cfg_ok = 1'b0;
  end

  assign xfer     = rd_req && rd_ready;
  assign last_grp = (grp_q == cur_q.groups - 1'b1);
  assign last_stg = (stage_q == nstg_q - 3'd1);

  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = cfg_ok ? S_LOAD : S_FIN;
      S_LOAD:  begin busy = 1'b1; state_d = S_ISSUE; end
      S_ISSUE: begin
        busy   = 1'b1;
        rd_req = !full;
        if (xfer && last_grp) state_d = S_DRAIN;
      end
      S_DRAIN: begin busy = 1'b1; if (zero) state_d = S_NEXT; end
      S_NEXT:  begin busy = 1'b1; state_d = last_stg ? S_FIN : S_ISSUE; end
      S_FIN:   begin done = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  // Config snapshot; only the start cycle in IDLE may overwrite it.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start)
      for (int i = 0; i < MAX_STAGES; i++)
        cfg_q[i] <= '{factor: cfg_factor[i], groups: cfg_groups[i], tw_step: cfg_tw_step[i],
                      tw_ceil: cfg_tw_ceil[i], tw_time: cfg_tw_time[i]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      nstg_q  <= '0;
      stage_q <= '0;
      grp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        nstg_q <= cfg_num_stages;
        if (!cfg_ok) err_q <= 1'b1;
      end
      if (uflow || (state_q == S_IDLE && wb_valid)) err_q <= 1'b1;
      if (state_q == S_LOAD) begin
        stage_q <= '0;
        cur_q   <= cfg_q[0];
        grp_q   <= '0;
      end
      // Radix only advances here, after DRAIN has seen the pipeline empty.
      if (state_q == S_NEXT && !last_stg) begin
        stage_q <= stage_q + 3'd1;
        cur_q   <= cfg_q[stage_q + 3'd1];
        grp_q   <= '0;
      end
      if (xfer && !last_grp) grp_q <= grp_q + 1'b1;
    end
  end

  assign rd_grp  = grp_q;
  assign stage   = stage_q;
  assign factor  = cur_q.factor;
  assign tw_step = cur_q.tw_step;
  assign tw_ceil = cur_q.tw_ceil;
  assign tw_time = cur_q.tw_time;
  assign err     = err_q;
endmodule

// File: tb/tb_mrd_rdx_stage_sched.sv
// Scoreboard bench for mrd_rdx_stage_sched: expected transfers/done pulses are
// queued at stimulus time and popped by an independent negedge monitor.
module tb_mrd_rdx_stage_sched;
  localparam int MS = 6, GW = 10, TW = 8, MO = 16;

  typedef struct packed {
    logic [2:0]    stg;
    logic [GW-1:0] grp;
    logic [2:0]    fac;
    logic [TW-1:0] tstep;
    logic [TW-1:0] tceil;
    logic [TW-1:0] ttime;
  } xfer_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rd_ready = 1'b1, wb_valid = 1'b0;
  logic [2:0]             cfg_num_stages = '0;
  logic [MS-1:0][2:0]     cfg_factor = '0;
  logic [MS-1:0][GW-1:0]  cfg_groups = '0;
  logic [MS-1:0][TW-1:0]  cfg_tw_step = '0, cfg_tw_ceil = '0, cfg_tw_time = '0;
  logic           rd_req, busy, done, err;
  logic [GW-1:0]  rd_grp;
  logic [2:0]     stage, factor;
  logic [TW-1:0]  tw_step, tw_ceil, tw_time;

  mrd_rdx_stage_sched #(.MAX_STAGES(MS), .wGRP(GW), .wTW(TW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_stages(cfg_num_stages),
    .cfg_factor(cfg_factor), .cfg_groups(cfg_groups), .cfg_tw_step(cfg_tw_step),
    .cfg_tw_ceil(cfg_tw_ceil), .cfg_tw_time(cfg_tw_time), .rd_req(rd_req),
    .rd_ready(rd_ready), .rd_grp(rd_grp), .stage(stage), .factor(factor),
    .tw_step(tw_step), .tw_ceil(tw_ceil), .tw_time(tw_time), .wb_valid(wb_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  xfer_t exp_q[$];
  bit    exp_done[$];
  int    wb_due[$];
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0, n_xfer = 0, n_done = 0, tb_out = 0, wb_delay = 5;
  int    last_wb = 0, last_stg = 0, last_fac = 0;
  bit    wb_hold = 0, wb_one = 0, wb_spur = 0, tog = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Datapath stand-in: retires each issued group wb_delay cycles later.
  initial forever begin
    @(posedge clk); #1;
    wb_valid = 1'b0;
    if (wb_spur) begin
      wb_valid = 1'b1; wb_spur = 0;
    end else if (wb_due.size() > 0 && (wb_one || (!wb_hold && wb_due[0] <= cyc))) begin
      wb_valid = 1'b1; wb_one = 0;
      void'(wb_due.pop_front());
    end
  end

  initial begin
    bit pat [4];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0;
    forever begin
      @(posedge clk); #1;
      if (tog) begin rd_ready = pat[k % 4]; k++; end
    end
  end

  // Monitor: transfers, done pulses, radix stability and stage-advance latency.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rd_req && rd_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) check("xfer_unexpected", {rd_grp, stage}, 64'hdead);
        else check("xfer", 64'(xfer_t'({stage, rd_grp, factor, tw_step, tw_ceil, tw_time})),
                   64'(exp_q.pop_front()));
        wb_due.push_back(cyc + wb_delay);
      end
      if (done) begin
        n_done++;
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else check("done_err", err, exp_done.pop_front());
        check("done_busy", busy, 0);
      end
      if (tb_out > 0) check("factor_hold", factor, last_fac);
      if (int'(stage) == last_stg + 1) check("stage_adv_lat", cyc - last_wb, 3);
      if (wb_valid) last_wb = cyc;
      if (rd_req && rd_ready) tb_out++;
      if (wb_valid && tb_out > 0) tb_out--;
    end
    last_fac = int'(factor);
    last_stg = int'(stage);
  end

  task automatic setup(input int ns, input int f0, input int f1, input int g0, input int g1,
                       input int base, input bit legal);
    cfg_num_stages = 3'(ns);
    cfg_factor = '0; cfg_groups = '0;
    cfg_factor[0] = 3'(f0); cfg_factor[1] = 3'(f1);
    cfg_groups[0] = GW'(g0); cfg_groups[1] = GW'(g1);
    for (int i = 0; i < MS; i++) begin
      cfg_tw_step[i] = TW'(base + i);
      cfg_tw_ceil[i] = TW'(base + 16 + i);
      cfg_tw_time[i] = TW'(base + 32 + i);
    end
    if (legal)
      for (int s = 0; s < ns; s++)
        for (int g = 0; g < (s == 0 ? g0 : g1); g++)
          exp_q.push_back({3'(s), GW'(g), 3'(s == 0 ? f0 : f1),
                           TW'(base + s), TW'(base + 16 + s), TW'(base + 32 + s)});
    exp_done.push_back(!legal);
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    int n;
    n = 0;
    while (n_done < target && n < max_cyc) begin @(posedge clk); n++; end
    check("done_timeout", n_done >= target, 1);
    repeat (3) @(posedge clk);
    check("done_count", n_done, target);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete(); exp_done.delete(); wb_due.delete(); tb_out = 0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_stage", stage, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int x0, n;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {rd_req, busy, done, err, stage, factor, rd_grp, tw_step, tw_ceil, tw_time}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // {4,3} x {3,4}: 7 transfers, latency and config-latch checks
    x0 = n_xfer;
    setup(2, 4, 3, 3, 4, 8'h10, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cfg_factor[0] = 3'd7; cfg_groups[1] = 10'd1;
    @(negedge clk);
    check("load_busy", busy, 1);
    check("load_rd_req", rd_req, 0);
    @(negedge clk);
    check("first_rd_req", rd_req, 1);
    wait_done(1, 200);
    check("t1_xfers", n_xfer - x0, 7);

    // outstanding limit: 40 groups, write-backs withheld
    x0 = n_xfer; wb_hold = 1;
    setup(1, 2, 0, 40, 0, 8'h40, 1);
    pulse_start();
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("stall_xfers", n_xfer - x0, MO);
    check("stall_rd_req", rd_req, 0);
    wb_one = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("one_more_xfer", n_xfer - x0, MO + 1);
    check("refull_rd_req", rd_req, 0);
    wb_hold = 0;
    wait_done(2, 400);

    // slow write-backs: radix 5 must persist until drained
    wb_delay = 20;
    setup(2, 5, 2, 3, 2, 8'h60, 1);
    pulse_start();
    wait_done(3, 300);
    wb_delay = 5;

    // rd_ready 1,0,0,1 pattern
    x0 = n_xfer; tog = 1; wb_delay = 3;
    setup(1, 3, 0, 5, 0, 8'h80, 1);
    pulse_start();
    wait_done(4, 300);
    tog = 0; rd_ready = 1'b1; wb_delay = 5;
    check("tog_xfers", n_xfer - x0, 5);

    // reset in stage 1, then a clean rerun
    setup(2, 4, 3, 3, 4, 8'h20, 1);
    pulse_start();
    n = 0;
    while (stage !== 3'd1 && n < 200) begin @(negedge clk); n++; end
    check("reach_stage1", stage, 1);
    do_reset();
    x0 = n_xfer;
    setup(2, 4, 3, 3, 4, 8'h30, 1);
    pulse_start();
    wait_done(5, 200);
    check("rerun_xfers", n_xfer - x0, 7);
    check("rerun_err", err, 0);

    // spurious write-back while idle
    wb_spur = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_wb_err", err, 1);

    // illegal configs: bad radix, zero stages, zero groups
    do_reset();
    @(negedge clk);
    check("err_cleared", err, 0);
    setup(2, 7, 3, 3, 4, 8'h50, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin @(negedge clk); check("illegal_busy", busy, 0); end
    check("illegal_err", err, 1);
    wait_done(6, 50);
    setup(0, 2, 2, 1, 1, 8'h50, 0);
    pulse_start();
    wait_done(7, 50);
    setup(2, 2, 4, 2, 0, 8'h50, 0);
    pulse_start();
    wait_done(8, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mrd_rdx_stage_sched.md
Name: mrd_rdx_stage_sched

Overview:
- Stage sequencer for the mixed-radix (2/3/4/5) DFT engine; drives the radix/twiddle datapath through every stage of one transform.
- Per stage: presents factor and twiddle-ROM parameters, issues one read request per butterfly group, counts write-backs returning from the datapath, and drains the pipeline before the factor may change.
- Sits between the top-level DFT controller (start/size config) and the memory address generator feeding the radix unit.

Parameters:
- MAX_STAGES, 6, maximum stages per transform.
- wGRP, 10, width of per-stage group count.
- wTW, 8, width of each twiddle-ROM parameter.
- MAX_OUTST, 16, maximum groups in flight (issued, not written back).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transform; ignored unless idle.
- cfg_num_stages  in  3  number of stages, 1..MAX_STAGES.
- cfg_factor  in  MAX_STAGES x 3  radix per stage (2,3,4,5).
- cfg_groups  in  MAX_STAGES x wGRP  butterfly groups per stage (N/factor), must be >=1.
- cfg_tw_step, cfg_tw_ceil, cfg_tw_time  in  MAX_STAGES x wTW each  twiddle ROM addr step / exp ceiling / exp repeat per stage.
- rd_req  out  1  request to issue one group read.
- rd_ready  in  1  address generator accepts; a transfer occurs when rd_req and rd_ready are both high.
- rd_grp  out  wGRP  group index within the current stage.
- stage  out  3  current stage index.
- factor  out  3  current radix, held constant for the whole stage including drain.
- tw_step, tw_ceil, tw_time  out  wTW  current stage twiddle parameters.
- wb_valid  in  1  one group written back by the datapath.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at transform completion.
- err  out  1  sticky; wb_valid arrived with zero outstanding, or a config was illegal at start.

Behaviour:
- Reset values: rd_req=0, rd_grp=0, stage=0, factor=0, tw_*=0, busy=0, done=0, err=0, outstanding count=0; FSM goes to IDLE.
- Config latch: cfg_* is sampled into internal registers on the start cycle. Later changes to cfg_* have no effect until the next start.
- Illegal config: num_stages 0 or >MAX_STAGES, any used factor outside {2,3,4,5}, or any used group count 0.
  - Sets err and pulses done the next cycle; busy stays 0.
- FSM states: IDLE, LOAD, ISSUE, DRAIN, NEXT, FIN.
  - IDLE: on a legal start -> LOAD; busy=1.
  - LOAD (1 cycle): drive factor/tw_* from stage-0 config; rd_grp=0 -> ISSUE. rd_req first rises the cycle after LOAD, i.e. 2 cycles after start.
  - ISSUE: rd_req=1 while outstanding<MAX_OUTST.
    - On each transfer rd_grp increments.
    - On the transfer of group cfg_groups-1 -> DRAIN, with rd_req low the following cycle.
  - DRAIN: rd_req=0; wait for outstanding==0 -> NEXT. If outstanding is already 0 on entry, leave DRAIN the next cycle.
  - NEXT (1 cycle):
    - If this was the last stage -> FIN.
    - Otherwise stage+1, load that stage's factor/tw_*, rd_grp=0 -> ISSUE.
  - FIN: done=1 for one cycle; busy=0; stage, factor and tw_* hold their last values -> IDLE.
- Outstanding counter:
  - +1 on each transfer, -1 on each wb_valid, net 0 when both occur in the same cycle.
  - Width ceil(log2(MAX_OUTST+1)).
  - wb_valid while the count is 0 sets err and the count stays 0.
  - wb_valid in IDLE also sets err.
- Stall: rd_req drops to 0 combinationally from the registered count when outstanding==MAX_OUTST, and reasserts the cycle after a wb_valid.
- rd_ready low holds rd_req, rd_grp and stage unchanged; there is no timeout.
- Factor/tw_* never change while outstanding>0. This is the guarantee the datapath relies on, since its output mux and pipeline-depth selection follow factor.
- start while busy is ignored and does not set err.
- Reset mid-transform returns to IDLE within one cycle: all outputs take reset values and in-flight write-backs are discarded.
- err clears only on reset.

Decomposition:
- Package mrd_pkg holds:
  - the factor encodings RDX2..RDX5 (3'd2..3'd5), MAX_STAGES, and the stage-config struct {factor, groups, tw_step, tw_ceil, tw_time};
  - the FSM state enum.
- One sub-module, mrd_outst_cnt: up/down counter with full/zero flags and the underflow flag, reused by the memory write-back path.

Test Plan:
- N=12, stages {4,3}, groups {3,4}, rd_ready=1, write-backs returned 5 cycles after issue -> stage 0: rd_grp 0..2 with factor=4; drain; stage 1: rd_grp 0..3 with factor=3; done pulses once; 7 transfers total.
- MAX_OUTST=16, groups=40, no wb_valid -> exactly 16 transfers, then rd_req=0; one wb_valid -> one further transfer in the next cycle.
- Write-back held back 20 cycles in stage 0 of {5,2} -> factor stays 5 until outstanding=0; stage=1 appears in the cycle after the last wb_valid + DRAIN exit.
- rd_ready toggled 1,0,0,1 -> rd_grp advances only on ready cycles; no group is skipped or duplicated.
- cfg_factor[0]=7 at start -> err=1, done pulse, busy stays 0, no rd_req; spurious wb_valid in IDLE -> err=1.
- rst_n low mid-stage-1 -> next cycle: busy=0, rd_req=0, stage=0; a new start then runs a complete clean transform.
